// File: rtl/mips_pkg.sv
// Shared types and helpers for the 8-bit-datapath multicycle MIPS fetch path.
package mips_pkg;

   localparam int IRWRITE_W = 4;

   typedef enum logic [2:0] {IDLE, RD, WAIT, CAP, DONE} fetch_state_t;

   // One-hot IRWrite strobe; for a 2-bit index, 3-index is simply ~index.
   function automatic logic [IRWRITE_W-1:0] byte_sel(input logic [1:0] index,
                                                     input logic       big_endian);
      logic [1:0] bit_idx;
      bit_idx = big_endian ? ~index : index;
      return IRWRITE_W'(1) << bit_idx;
   endfunction

endpackage

// File: rtl/fetch_lat_cnt.sv
// Loadable down-counter that times the WAIT state for multi-cycle memory latency.
module fetch_lat_cnt #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch_seq.sv
// Byte-fetch sequencer: reads the four bytes of one instruction and strobes
// them into instr_reg one at a time through IRWrite.
module instr_fetch_seq
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [ADDR_W-1:0]    pc_i,
   input  logic [7:0]           mem_rdata_i,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic                 mem_rd_o,
   output logic [IRWRITE_W-1:0] ir_write_o,
   output logic [7:0]           byte_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [ADDR_W-1:0]    pc_next_o
);

   fetch_state_t          state_q, state_d;
   logic [1:0]            idx_q, idx_d, idx_inc;
   logic [ADDR_W-1:0]     pc_q, pc_d, addr_q, addr_d, pc_next_q, pc_next_d;
   logic                  mem_rd_q, mem_rd_d, busy_q, busy_d;
   logic                  done_q, done_d, err_q, err_d;
   logic [IRWRITE_W-1:0]  irw_q, irw_d;
   logic                  lat_load, lat_dec, lat_zero;

   assign idx_inc = idx_q + 2'd1;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      pc_next_d = pc_next_q;
      busy_d    = busy_q;
      mem_rd_d  = 1'b0;
      irw_d     = '0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      lat_load  = 1'b0;
      lat_dec   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (pc_i[1:0] == 2'b00) begin
                  pc_d     = pc_i;
                  idx_d    = 2'd0;
                  addr_d   = pc_i;
                  mem_rd_d = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = RD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RD: begin
            if (MEM_LAT > 1) begin
               lat_load = 1'b1;
               state_d  = WAIT;
            end else begin
               irw_d   = byte_sel(idx_q, BIG_ENDIAN);
               state_d = CAP;
            end
         end
         WAIT: begin
            if (lat_zero) begin
               irw_d   = byte_sel(idx_q, BIG_ENDIAN);
               state_d = CAP;
            end else begin
               lat_dec = 1'b1;
            end
         end
         CAP: begin
            if (idx_q == 2'd3) begin
               done_d    = 1'b1;
               busy_d    = 1'b0;
               pc_next_d = pc_q + ADDR_W'(4);
               state_d   = DONE;
            end else begin
               idx_d    = idx_inc;
               addr_d   = pc_q + ADDR_W'(idx_inc);
               mem_rd_d = 1'b1;
               state_d  = RD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort overrides every transition; in IDLE it also drops a same-cycle start.
      if (abort_i) begin
         state_d   = IDLE;
         pc_d      = pc_q;
         idx_d     = idx_q;
         addr_d    = addr_q;
         pc_next_d = pc_next_q;
         busy_d    = 1'b0;
         mem_rd_d  = 1'b0;
         irw_d     = '0;
         done_d    = 1'b0;
         err_d     = 1'b0;
         lat_load  = 1'b0;
         lat_dec   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= 2'd0;
         pc_q      <= '0;
         addr_q    <= '0;
         pc_next_q <= '0;
         busy_q    <= 1'b0;
         mem_rd_q  <= 1'b0;
         irw_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         pc_next_q <= pc_next_d;
         busy_q    <= busy_d;
         mem_rd_q  <= mem_rd_d;
         irw_q     <= irw_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   generate
      if (MEM_LAT > 1) begin : g_lat_cnt
         fetch_lat_cnt #(.CNT_W(3)) u_lat_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (lat_load),
            .load_val_i (3'(MEM_LAT - 2)),
            .dec_i      (lat_dec),
            .zero_o     (lat_zero)
         );
      end else begin : g_no_lat_cnt
         // WAIT is unreachable here; load and dec are never both high, so this is constant 1.
         assign lat_zero = ~(lat_load & lat_dec);
      end
   endgenerate

   assign mem_addr_o = addr_q;
   assign mem_rd_o   = mem_rd_q;
   assign ir_write_o = abort_i ? '0 : irw_q;
   assign byte_o     = (state_q == CAP) ? mem_rdata_i : 8'h00;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign pc_next_o  = pc_next_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: three instances (LE/lat1, BE/lat1, LE/lat3) share stimulus.
module tb_instr_fetch_seq;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [31:0] pc;

   logic [7:0]  rdata_a, rdata_b, rdata_c;
   logic [31:0] addr_a, addr_b, addr_c, pcn_a, pcn_b, pcn_c;
   logic        rd_a, rd_b, rd_c, busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c, err_a, err_b, err_c;
   logic [3:0]  irw_a, irw_b, irw_c;
   logic [7:0]  byte_a, byte_b, byte_c;
   logic [31:0] ir_a, ir_b, ir_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_fetch_seq #(.ADDR_W(32), .MEM_LAT(1), .BIG_ENDIAN(1'b0)) u_a (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pc_i(pc),
      .mem_rdata_i(rdata_a), .mem_addr_o(addr_a), .mem_rd_o(rd_a), .ir_write_o(irw_a),
      .byte_o(byte_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .pc_next_o(pcn_a));

   instr_fetch_seq #(.ADDR_W(32), .MEM_LAT(1), .BIG_ENDIAN(1'b1)) u_b (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pc_i(pc),
      .mem_rdata_i(rdata_b), .mem_addr_o(addr_b), .mem_rd_o(rd_b), .ir_write_o(irw_b),
      .byte_o(byte_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .pc_next_o(pcn_b));

   instr_fetch_seq #(.ADDR_W(32), .MEM_LAT(3), .BIG_ENDIAN(1'b0)) u_c (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pc_i(pc),
      .mem_rdata_i(rdata_c), .mem_addr_o(addr_c), .mem_rd_o(rd_c), .ir_write_o(irw_c),
      .byte_o(byte_c), .busy_o(busy_c), .done_o(done_c), .err_o(err_c), .pc_next_o(pcn_c));

   // 0x100..0x103 hold 11,22,33,44; addresses with bit 9 set hold E1,D2,C3,B4.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [7:0] b;
      b = 8'h11 * ({6'd0, a[1:0]} + 8'd1);
      if (a[9]) b = b ^ 8'hF0;
      return b;
   endfunction

   // Memory returns data after the read strobe and holds it until the next read.
   always @(posedge clk) begin
      if (rd_a) rdata_a <= mem_byte(addr_a);
      if (rd_b) rdata_b <= mem_byte(addr_b);
      if (rd_c) rdata_c <= mem_byte(addr_c);
   end

   // instr_reg models.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (irw_a[i]) ir_a[8*i +: 8] <= byte_a;
         if (irw_b[i]) ir_b[8*i +: 8] <= byte_b;
         if (irw_c[i]) ir_c[8*i +: 8] <= byte_c;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; pc = 32'h0;
      rdata_a = 8'h0; rdata_b = 8'h0; rdata_c = 8'h0;
      ir_a = 32'h0; ir_b = 32'h0; ir_c = 32'h0;
      step(); step();

      // Reset state
      check("rst_addr", addr_a, 32'h0);
      check("rst_pcn", pcn_a, 32'h0);
      check("rst_outs", {19'd0, rd_a, irw_a, byte_a, busy_a, done_a, err_a}, 32'h0);
      rst = 1'b0;
      step();

      // Fetch at 0x100 on all three instances; a start during DONE/busy is ignored
      start = 1'b1; pc = 32'h100;
      step();
      start = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         int k;
         k = (c - 1) / 2;
         if (c <= 8) begin
            check("a_rd", rd_a, (c % 2) == 1);
            if (c % 2 == 1) check("a_addr", addr_a, 32'h100 + k);
            check("a_irw", irw_a, (c % 2 == 0) ? (32'd1 << k) : 32'd0);
            check("b_irw", irw_b, (c % 2 == 0) ? (32'd8 >> k) : 32'd0);
            if (c % 2 == 0) check("a_byte", byte_a, 32'h11 * (k + 1));
            else            check("a_byte_idle", byte_a, 32'h0);
            check("a_busy", busy_a, 32'd1);
         end
         check("a_done", done_a, c == 9);
         check("b_done", done_b, c == 9);
         check("c_rd", rd_c, (c % 4 == 1) && (c <= 13));
         check("c_irw", irw_c, ((c % 4 == 0) && (c <= 16)) ? (32'd1 << (c / 4 - 1)) : 32'd0);
         check("c_done", done_c, c == 17);
         if (c == 9) begin
            check("a_pcn", pcn_a, 32'h104);
            start = 1'b1; pc = 32'h200;
         end
         if (c == 10) begin
            start = 1'b0;
            check("a_done_start_ign", {30'd0, rd_a, busy_a}, 32'h0);
            check("a_pcn_hold", pcn_a, 32'h104);
         end
         if (c == 17) check("c_pcn", pcn_c, 32'h104);
         step();
      end
      check("a_ir_le", ir_a, 32'h44332211);
      check("b_ir_be", ir_b, 32'h11223344);
      check("c_ir_lat3", ir_c, 32'h44332211);

      // Misaligned start
      start = 1'b1; pc = 32'h102;
      step();
      start = 1'b0;
      check("a_err", err_a, 32'd1);
      check("c_err", err_c, 32'd1);
      check("a_err_quiet", {27'd0, busy_a, rd_a, irw_a == 4'h0}, 32'h1);
      step();
      check("a_err_pulse", err_a, 32'd0);
      check("a_err_idle", rd_a, 32'd0);

      // Abort during CAP of byte 2
      start = 1'b1; pc = 32'h100;
      step();
      start = 1'b0;
      for (int c = 2; c <= 6; c++) step();
      abort = 1'b1;
      #1;
      check("a_abort_irw", irw_a, 32'h0);
      step();
      abort = 1'b0;
      check("a_abort_idle", {30'd0, rd_a, busy_a}, 32'h0);
      for (int c = 7; c <= 10; c++) begin
         check("a_abort_nodone", done_a, 32'd0);
         step();
      end
      check("a_abort_pcn", pcn_a, 32'h104);

      // Fresh fetch after abort
      start = 1'b1; pc = 32'h200;
      step();
      start = 1'b0;
      check("a_re_addr", addr_a, 32'h200);
      check("a_re_rd", rd_a, 32'd1);
      for (int c = 2; c <= 9; c++) step();
      check("a_re_done", done_a, 32'd1);
      check("a_re_pcn", pcn_a, 32'h204);
      step();
      check("a_re_ir", ir_a, 32'hB4C3D2E1);
      for (int c = 0; c < 8; c++) step();

      // Address wrap at top of memory, then reset while instance c is in WAIT
      start = 1'b1; pc = 32'hFFFF_FFFC;
      step();
      start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         if (c % 2 == 1 && c <= 7) check("a_wrap_addr", addr_a, 32'hFFFF_FFFC + (c - 1) / 2);
         if (c == 9) begin
            check("a_wrap_done", done_a, 32'd1);
            check("a_wrap_pcn", pcn_a, 32'h0);
         end
         step();
      end
      check("c_in_wait", {30'd0, rd_c, busy_c}, 32'h1);
      rst = 1'b1;
      #1;
      check("c_rst_outs", {19'd0, rd_c, irw_c, byte_c, busy_c, done_c, err_c}, 32'h0);
      check("c_rst_addr", addr_c, 32'h0);
      check("c_rst_pcn", pcn_c, 32'h0);
      step();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         check("c_post_rst", {27'd0, rd_c, irw_c}, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
